// File: rtl/parking_pkg.sv
//------------------------------------------------------------------------------
// Module : parking_pkg
// Brief  : Shared types and default sizing for the parking gate controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package parking_pkg;

  localparam int c_n_spots     = 4;
  localparam int c_spot_w      = 2;
  localparam int c_open_cycles = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  typedef enum logic {
    ENTER = 1'b0,
    EXIT  = 1'b1
  } served_t;

endpackage

`default_nettype wire

// File: rtl/parking_gate_controller_free_spot_finder.sv
//------------------------------------------------------------------------------
// Module : free_spot_finder
// Brief  : Priority encoder returning the lowest-numbered free spot.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module free_spot_finder #(
  parameter int N_SPOTS = 4,
  parameter int SPOT_W  = 2
) (
  input  logic [N_SPOTS-1:0] occ,
  output logic [SPOT_W-1:0]  free_idx,
  output logic               free_valid
);

  // Scanning downward lets the lowest free index win the last assignment.
  always_comb begin
    free_idx   = '0;
    free_valid = 1'b0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        free_idx   = SPOT_W'(i);
        free_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/parking_gate_controller.sv
//------------------------------------------------------------------------------
// Module : parking_gate_controller
// Brief  : Arbitrates entry/exit requests, owns spot occupancy, times the gate.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int N_SPOTS     = c_n_spots,
  parameter int SPOT_W      = c_spot_w,
  parameter int OPEN_CYCLES = c_open_cycles
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enter,
  input  logic               exit,
  input  logic [SPOT_W-1:0]  switch,
  output logic               door_open,
  output logic               enter_ack,
  output logic               exit_ack,
  output logic [SPOT_W-1:0]  spot,
  output logic [N_SPOTS-1:0] F,
  output logic [SPOT_W:0]    capacity,
  output logic               full,
  output logic               err
);

  localparam int              c_cnt_w    = $clog2(OPEN_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(OPEN_CYCLES - 1);

  state_t               r_state;
  served_t              r_last;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [SPOT_W-1:0]    w_free_idx;
  logic                 w_free_valid;
  logic [SPOT_W:0]      w_count;
  logic                 w_sel_occ;
  logic                 w_ev;
  logic                 w_xv;
  logic                 w_xe;
  logic                 w_grant_enter;
  logic                 w_grant_exit;

  free_spot_finder #(
    .N_SPOTS (N_SPOTS),
    .SPOT_W  (SPOT_W)
  ) u_free_spot_finder (
    .occ        (F),
    .free_idx   (w_free_idx),
    .free_valid (w_free_valid)
  );

  always_comb begin
    w_count = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      w_count = w_count + (SPOT_W + 1)'(F[i]);
    end
  end

  assign capacity  = (SPOT_W + 1)'(N_SPOTS) - w_count;
  assign full      = &F;

  assign w_sel_occ = F[switch];
  assign w_ev      = enter & ~full & w_free_valid;
  assign w_xv      = exit & w_sel_occ;
  assign w_xe      = exit & ~w_sel_occ;

  // On a tie the side not served last wins; the loser simply stays pending.
  assign w_grant_enter = w_ev & (~w_xv | (r_last == EXIT));
  assign w_grant_exit  = w_xv & (~w_ev | (r_last == ENTER));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_last    <= EXIT;
      r_cnt     <= '0;
      F         <= '0;
      spot      <= '0;
      door_open <= 1'b0;
      enter_ack <= 1'b0;
      exit_ack  <= 1'b0;
      err       <= 1'b0;
    end else begin
      enter_ack <= 1'b0;
      exit_ack  <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        IDLE: begin
          door_open <= 1'b0;
          err       <= w_xe;
          if (w_grant_enter) begin
            F[w_free_idx] <= 1'b1;
            spot          <= w_free_idx;
            enter_ack     <= 1'b1;
            r_last        <= ENTER;
            door_open     <= 1'b1;
            r_cnt         <= c_cnt_load;
            r_state       <= OPEN;
          end else if (w_grant_exit) begin
            F[switch] <= 1'b0;
            spot      <= switch;
            exit_ack  <= 1'b1;
            r_last    <= EXIT;
            door_open <= 1'b1;
            r_cnt     <= c_cnt_load;
            r_state   <= OPEN;
          end
        end
        OPEN: begin
          if (r_cnt == '0) begin
            door_open <= 1'b0;
            r_state   <= CLOSE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CLOSE: begin
          door_open <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          door_open <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
//------------------------------------------------------------------------------
// Module : tb_parking_gate_controller
// Brief  : Directed self-checking bench for parking_gate_controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_parking_gate_controller;

  logic       CLK;
  logic       RST;
  logic       enter;
  logic       exit;
  logic [1:0] switch;
  logic       door_open;
  logic       enter_ack;
  logic       exit_ack;
  logic [1:0] spot;
  logic [3:0] F;
  logic [2:0] capacity;
  logic       full;
  logic       err;

  int checks;
  int errors;

  parking_gate_controller #(
    .N_SPOTS     (4),
    .SPOT_W      (2),
    .OPEN_CYCLES (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .enter     (enter),
    .exit      (exit),
    .switch    (switch),
    .door_open (door_open),
    .enter_ack (enter_ack),
    .exit_ack  (exit_ack),
    .spot      (spot),
    .F         (F),
    .capacity  (capacity),
    .full      (full),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST    = 1'b0;
    enter  = 1'b0;
    exit   = 1'b0;
    switch = 2'd0;
    repeat (2) step();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({door_open, enter_ack, exit_ack, err, full} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {door_open, enter_ack, exit_ack, err, full});
    end
    checks++;
    if (F !== 4'b0000 || spot !== 2'd0 || capacity !== 3'd4) begin
      errors++;
      $display("FAIL reset_state: got F=%b spot=%0d cap=%0d expected F=0000 spot=0 cap=4", F, spot, capacity);
    end
  endtask

  task automatic test_entry();
    bit bad;
    enter = 1'b1;
    step();
    checks++;
    if (enter_ack !== 1'b1 || spot !== 2'd0 || F !== 4'b0001 || door_open !== 1'b1 || capacity !== 3'd3) begin
      errors++;
      $display("FAIL entry_first: got ack=%b spot=%0d F=%b door=%b cap=%0d expected 1 0 0001 1 3",
               enter_ack, spot, F, door_open, capacity);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (door_open !== 1'b1 || enter_ack !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL door_hold: door_open=%b ack=%b expected door high for 4 cycles, single ack", door_open, enter_ack);
    end
    step();
    checks++;
    if (door_open !== 1'b0) begin
      errors++;
      $display("FAIL door_close: got %b expected 0", door_open);
    end
    step();
    checks++;
    if (enter_ack !== 1'b0 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL early_grant: ack=%b door=%b expected 0 0", enter_ack, door_open);
    end
    step();
    checks++;
    if (enter_ack !== 1'b1 || spot !== 2'd1 || F !== 4'b0011) begin
      errors++;
      $display("FAIL entry_second: got ack=%b spot=%0d F=%b expected 1 1 0011", enter_ack, spot, F);
    end
    enter = 1'b0;
  endtask

  task automatic test_full();
    bit bad;
    repeat (5) step();
    enter = 1'b1;
    step();
    repeat (5) step();
    step();
    checks++;
    if (enter_ack !== 1'b1 || spot !== 2'd3 || F !== 4'b1111 || full !== 1'b1 || capacity !== 3'd0) begin
      errors++;
      $display("FAIL fill: got ack=%b spot=%0d F=%b full=%b cap=%0d expected 1 3 1111 1 0",
               enter_ack, spot, F, full, capacity);
    end
    repeat (5) step();
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (enter_ack !== 1'b0 || err !== 1'b0 || door_open !== 1'b0 || F !== 4'b1111) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_block: ack=%b err=%b door=%b F=%b expected 0 0 0 1111", enter_ack, err, door_open, F);
    end
    exit   = 1'b1;
    switch = 2'd2;
    step();
    exit = 1'b0;
    checks++;
    if (exit_ack !== 1'b1 || enter_ack !== 1'b0 || F !== 4'b1011 || spot !== 2'd2 || full !== 1'b0 || capacity !== 3'd1) begin
      errors++;
      $display("FAIL exit_when_full: got xack=%b eack=%b F=%b spot=%0d full=%b cap=%0d expected 1 0 1011 2 0 1",
               exit_ack, enter_ack, F, spot, full, capacity);
    end
    repeat (5) step();
    step();
    checks++;
    if (enter_ack !== 1'b1 || spot !== 2'd2 || F !== 4'b1111) begin
      errors++;
      $display("FAIL regrant: got ack=%b spot=%0d F=%b expected 1 2 1111", enter_ack, spot, F);
    end
    enter = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    enter = 1'b1;
    step();
    enter = 1'b0;
    repeat (5) step();
    enter = 1'b1;
    step();
    enter = 1'b0;
    repeat (5) step();
    exit   = 1'b1;
    switch = 2'd1;
    step();
    exit = 1'b0;
    checks++;
    if (exit_ack !== 1'b1 || F !== 4'b0001 || spot !== 2'd1) begin
      errors++;
      $display("FAIL rr_setup: got xack=%b F=%b spot=%0d expected 1 0001 1", exit_ack, F, spot);
    end
    repeat (5) step();
    enter  = 1'b1;
    exit   = 1'b1;
    switch = 2'd0;
    step();
    enter = 1'b0;
    checks++;
    if (enter_ack !== 1'b1 || exit_ack !== 1'b0 || spot !== 2'd1 || F !== 4'b0011) begin
      errors++;
      $display("FAIL tie_entry: got eack=%b xack=%b spot=%0d F=%b expected 1 0 1 0011", enter_ack, exit_ack, spot, F);
    end
    repeat (5) step();
    checks++;
    if (F !== 4'b0011 || exit_ack !== 1'b0) begin
      errors++;
      $display("FAIL open_ignores_exit: got F=%b xack=%b expected 0011 0", F, exit_ack);
    end
    step();
    exit = 1'b0;
    checks++;
    if (exit_ack !== 1'b1 || enter_ack !== 1'b0 || F !== 4'b0010 || spot !== 2'd0) begin
      errors++;
      $display("FAIL tie_exit_pending: got xack=%b eack=%b F=%b spot=%0d expected 1 0 0010 0", exit_ack, enter_ack, F, spot);
    end
  endtask

  task automatic test_err();
    do_reset();
    exit   = 1'b1;
    switch = 2'd3;
    step();
    exit = 1'b0;
    checks++;
    if (err !== 1'b1 || exit_ack !== 1'b0 || F !== 4'b0000 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b xack=%b F=%b door=%b expected 1 0 0000 0", err, exit_ack, F, door_open);
    end
    step();
    checks++;
    if (err !== 1'b0 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: got err=%b door=%b expected 0 0", err, door_open);
    end
    enter  = 1'b1;
    exit   = 1'b1;
    switch = 2'd3;
    step();
    enter = 1'b0;
    exit  = 1'b0;
    checks++;
    if (err !== 1'b1 || enter_ack !== 1'b1 || exit_ack !== 1'b0 || spot !== 2'd0 || F !== 4'b0001) begin
      errors++;
      $display("FAIL err_with_entry: got err=%b eack=%b xack=%b spot=%0d F=%b expected 1 1 0 0 0001",
               err, enter_ack, exit_ack, spot, F);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enter = 1'b1;
    step();
    step();
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (door_open !== 1'b0 || F !== 4'b0000 || enter_ack !== 1'b0 || capacity !== 3'd4) begin
      errors++;
      $display("FAIL async_reset: got door=%b F=%b ack=%b cap=%0d expected 0 0000 0 4", door_open, F, enter_ack, capacity);
    end
    step();
    RST = 1'b1;
    checks++;
    if (enter_ack !== 1'b0 || door_open !== 1'b0 || capacity !== 3'd4) begin
      errors++;
      $display("FAIL post_reset: got ack=%b door=%b cap=%0d expected 0 0 4", enter_ack, door_open, capacity);
    end
    step();
    enter = 1'b0;
    checks++;
    if (enter_ack !== 1'b1 || spot !== 2'd0 || F !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_grant: got ack=%b spot=%0d F=%b expected 1 0 0001", enter_ack, spot, F);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_entry();
    test_full();
    test_round_robin();
    test_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequencing controller for the single shared parking gate. Arbitrates between the entry and exit requesters, allocates the lowest-numbered free spot on entry, releases the selected spot on exit, and owns the occupancy register. It holds the door open for a fixed number of cycles per admitted car. It sits between the enter/exit sensors and spot switch on one side and the gate actuator and status outputs on the other.

## Interface
Parameters:
- N_SPOTS, 4, number of parking spots.
- SPOT_W, 2, spot index width, equal to clog2(N_SPOTS).
- OPEN_CYCLES, 4, cycles the door stays open per admitted car; must be ≥1.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset; asynchronous, active-low (RST=0 resets).
- enter  in  1  level entry request from entry sensor.
- exit  in  1  level exit request from exit sensor.
- switch  in  SPOT_W  spot being vacated; sampled with exit.
- door_open  out  1  gate actuator, 1 = open.
- enter_ack  out  1  one-cycle pulse: entry granted.
- exit_ack  out  1  one-cycle pulse: exit granted.
- spot  out  SPOT_W  spot allocated/released by the current grant; holds until next grant.
- F  out  N_SPOTS  occupancy bitmap, bit i = spot i occupied.
- capacity  out  SPOT_W+1  free-spot count, N_SPOTS − popcount(F).
- full  out  1  all spots occupied.
- err  out  1  one-cycle pulse: exit requested for an empty spot.

## Operation
- States: IDLE, OPEN, CLOSE.
- IDLE: door closed. Each edge evaluates:
  - ev = enter & !full.
  - xv = exit & F[switch].
  - xe = exit & !F[switch].
- Only ev: go OPEN, set F[a] where a = lowest free index, spot←a, enter_ack=1.
- Only xv: go OPEN, clear F[switch], spot←switch, exit_ack=1.
- ev and xv together: round-robin on last_served flag. Reset value is EXIT, so the first tie goes to entry. The loser stays pending and is re-evaluated on return to IDLE.
- xe with no grant this edge: err=1 for one cycle, stay IDLE, F unchanged. If ev and xe coincide, entry is granted and err still pulses.
- enter while full, with no exit: no grant, no err, stay IDLE.
- OPEN: door_open=1 for exactly OPEN_CYCLES cycles (down-counter), then CLOSE. enter/exit are ignored.
- CLOSE: door_open=0 for one cycle, requests ignored, then IDLE.
- last_served updates on every grant.
- capacity and full are combinational from F.
- Reset values: state=IDLE, F=0, spot=0, door_open=0, enter_ack=0, exit_ack=0, err=0, capacity=N_SPOTS, full=0, last_served=EXIT, counter=0.

## Timing
- Request sampled on edge k in IDLE. On that edge: state→OPEN, F/spot updated, and ack registered high during cycle k→k+1.
- door_open is high for OPEN_CYCLES cycles starting in the ack cycle, then low in CLOSE.
- Earliest next grant is OPEN_CYCLES+2 edges after the previous one.
- full/capacity reflect the new F in the ack cycle.
- RST assertion mid-OPEN: door_open, acks and F clear immediately (asynchronous). The first evaluation is on the first edge after RST deasserts.
- All outputs are registered except capacity and full.

## Structure
- Shared package parking_pkg holds:
  - state enum (IDLE, OPEN, CLOSE),
  - served enum (ENTER, EXIT),
  - default N_SPOTS, SPOT_W, OPEN_CYCLES constants.
- Sub-module free_spot_finder: combinational priority encoder over ~F, giving the lowest free index plus a valid flag.
- Popcount for capacity stays inline.

## Test plan
- Reset, then enter=1 held: enter_ack at first edge, spot=0, F=0001, door_open high 4 cycles, 1 closed cycle, next grant spot=1, F=0011.
- Fill F=1111 (full=1, capacity=0), enter=1 held: no ack, no err, door stays closed; then exit=1, switch=2: exit_ack, F=1011, and entry regranted later with spot=2.
- F=0001, enter=1 and exit=1 with switch=0 simultaneously from reset: entry wins (spot=1, F=0011). Next IDLE grants exit: F=0010, spot=0.
- F=0000, exit=1, switch=3: err pulse for one cycle, no ack, F unchanged, door closed.
- Assert RST=0 in the second OPEN cycle: door_open=0 and F=0000 immediately, without a clock edge. After release, state is IDLE and capacity=4.
